// File: rtl/id_stage_pipe.sv
// RV32I decode stage: IF->ID valid/ready intake, operand forwarding, load-use interlock,
// branch/jump resolution with wrong-path squash, and a registered valid/ready output to EX.
module id_stage_pipe #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned NFWD       = 2,
  parameter int unsigned KILL_SLOTS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_pc,
  input  logic [31:0]          in_inst,
  output logic [4:0]           raddr1,
  output logic [4:0]           raddr2,
  input  logic [31:0]          rdata1,
  input  logic [31:0]          rdata2,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [5*NFWD-1:0]    fwd_waddr,
  input  logic [32*NFWD-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]      fwd_pend,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_pc,
  output logic [2:0]           out_alusel,
  output logic                 out_funct,
  output logic [31:0]          out_data1,
  output logic [31:0]          out_data2,
  output logic [31:0]          out_extra,
  output logic                 out_we,
  output logic [4:0]           out_waddr,
  output logic                 out_ma_we,
  output logic                 out_ma_re,
  output logic [2:0]           out_ma_width,
  output logic                 out_illegal,
  output logic                 redir_valid,
  output logic [ADDR_W-1:0]    redir_pc
);

  localparam int unsigned CNT_W = 3;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_KILL} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               redir_q;
  logic               adv, haz, acc, issue;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_ext;

  assign opc    = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign f3     = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'd0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign pc_ext = 32'(in_pc);
  assign raddr1 = rs1;
  assign raddr2 = rs2;

  // Source usage per opcode
  logic re1, re2;
  always_comb begin
    re1 = 1'b0;
    re2 = 1'b0;
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: re1 = 1'b1;
      OPC_BRANCH, OPC_STORE, OPC_OP: begin re1 = 1'b1; re2 = 1'b1; end
      default: ;
    endcase
  end

  // Forwarding: descending scan so the lowest-index match overrides; its pend bit decides the hazard
  logic [31:0] src1, src2;
  logic        pend1, pend2;
  always_comb begin
    src1  = rdata1;
    src2  = rdata2;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[5*i +: 5] != 5'd0 && fwd_waddr[5*i +: 5] == rs1) begin
        src1  = fwd_wdata[32*i +: 32];
        pend1 = fwd_pend[i];
      end
      if (fwd_we[i] && fwd_waddr[5*i +: 5] != 5'd0 && fwd_waddr[5*i +: 5] == rs2) begin
        src2  = fwd_wdata[32*i +: 32];
        pend2 = fwd_pend[i];
      end
    end
    if (rs1 == 5'd0) src1 = 32'd0;
    if (rs2 == 5'd0) src2 = 32'd0;
  end

  assign adv      = ~out_valid | out_ready;
  assign haz      = (re1 & pend1) | (re2 & pend2);
  assign in_ready = ~rst & rdy & adv & ~haz;
  assign acc      = in_valid & in_ready;

  // Decode of the presented beat
  logic [2:0]        d_alusel, d_width;
  logic              d_funct, d_we, d_ma_we, d_ma_re, d_illegal, taken, cond;
  logic [31:0]       d_data1, d_data2, d_extra;
  logic [ADDR_W-1:0] target;
  always_comb begin
    d_alusel  = 3'd0;
    d_funct   = 1'b0;
    d_data1   = src1;
    d_data2   = src2;
    d_extra   = 32'd0;
    d_we      = 1'b1;
    d_ma_we   = 1'b0;
    d_ma_re   = 1'b0;
    d_width   = 3'd0;
    d_illegal = 1'b0;
    taken     = 1'b0;
    target    = in_pc + ADDR_W'(imm_b);
    case (f3)
      3'b000:  cond = (src1 == src2);
      3'b001:  cond = (src1 != src2);
      3'b100:  cond = ($signed(src1) <  $signed(src2));
      3'b101:  cond = ($signed(src1) >= $signed(src2));
      3'b110:  cond = (src1 <  src2);
      3'b111:  cond = (src1 >= src2);
      default: cond = 1'b0;
    endcase
    case (opc)
      OPC_LUI:   begin d_data1 = 32'd0; d_data2 = imm_u; end
      OPC_AUIPC: begin d_data1 = imm_u; d_data2 = pc_ext; end
      OPC_OPIMM: begin
        d_alusel = f3;
        if (f3 == 3'b001 || f3 == 3'b101) d_data2 = 32'(in_inst[24:20]);
        else                              d_data2 = imm_i;
        d_funct = (f3 == 3'b101) & in_inst[30];
      end
      OPC_OP:    begin d_alusel = f3; d_funct = in_inst[30]; end
      OPC_LOAD:  begin d_ma_re = 1'b1; d_width = f3; d_data2 = imm_i; end
      OPC_STORE: begin
        d_we = 1'b0; d_ma_we = 1'b1; d_width = f3; d_data2 = imm_s; d_extra = src2;
      end
      OPC_BRANCH: begin d_we = 1'b0; taken = cond; end
      OPC_JAL: begin
        d_data1 = 32'd0; d_data2 = pc_ext + 32'd4;
        taken   = 1'b1;  target  = in_pc + ADDR_W'(imm_j);
      end
      OPC_JALR: begin
        d_data1 = 32'd0; d_data2 = pc_ext + 32'd4;
        taken   = 1'b1;  target  = ADDR_W'(src1 + imm_i) & ~ADDR_W'(1);
      end
      default: begin d_illegal = 1'b1; d_we = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state; issue marks an accepted beat that is forwarded to EX rather than squashed
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    issue   = 1'b0;
    if (flush) begin
      state_n = S_RUN;
      cnt_n   = '0;
    end else if (rdy) begin
      case (state)
        S_KILL: begin
          if (acc) begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state_n = S_RUN;
          end
        end
        default: begin
          if (acc) begin
            issue = 1'b1;
            if (taken && KILL_SLOTS != 0) begin
              state_n = S_KILL;
              cnt_n   = CNT_W'(KILL_SLOTS);
            end else begin
              state_n = S_RUN;
            end
          end else if (haz && in_valid && adv) begin
            state_n = S_STALL;
          end else if (!haz) begin
            state_n = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_alusel   <= '0;
      out_funct    <= 1'b0;
      out_data1    <= '0;
      out_data2    <= '0;
      out_extra    <= '0;
      out_we       <= 1'b0;
      out_waddr    <= '0;
      out_ma_we    <= 1'b0;
      out_ma_re    <= 1'b0;
      out_ma_width <= '0;
      out_illegal  <= 1'b0;
      redir_q      <= 1'b0;
      redir_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      redir_q   <= 1'b0;
    end else if (rdy) begin
      redir_q <= issue & taken;
      if (adv) out_valid <= issue;
      if (issue) begin
        out_pc       <= in_pc;
        out_alusel   <= d_alusel;
        out_funct    <= d_funct;
        out_data1    <= d_data1;
        out_data2    <= d_data2;
        out_extra    <= d_extra;
        out_we       <= d_we & (rd != 5'd0);
        out_waddr    <= rd;
        out_ma_we    <= d_ma_we;
        out_ma_re    <= d_ma_re;
        out_ma_width <= d_width;
        out_illegal  <= d_illegal;
        redir_pc     <= target;
      end
    end
  end

  // A frozen stage must not present a redirect
  assign redir_valid = redir_q & rdy;

endmodule
